// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder on the memory side of the MMC. It accepts the MMC's
// offset-translated data request, inserts GNT_WAIT grant wait states, performs
// the access on a word-organised, byte-writable RAM and returns one response
// per accepted request, in accept order, exactly LATENCY cycles after grant.
//
// Parameters
//   ADDR_WIDTH : word-index bits, RAM holds 2**ADDR_WIDTH 32-bit words
//   GNT_WAIT   : cycles req_i must be held before gnt_o rises (0..3)
//   LATENCY    : cycles from the grant edge to rvalid_o (1..4)
//
// Ports
//   clk       in   clock, all state on the rising edge
//   rst_n     in   asynchronous active-low reset
//   req_i     in   request valid, held with its payload until gnt_o
//   addr_i    in   byte address relative to the DMEM base
//   we_i      in   1 = write, 0 = read
//   be_i      in   byte enables, bit n covers wdata_i[8n+7:8n]
//   wdata_i   in   write data
//   gnt_o     out  request accepted this cycle (combinational)
//   rvalid_o  out  one-cycle response strobe
//   rdata_o   out  read data, zero whenever rvalid_o is low or for writes
//   err_o     out  response error, only with DMEM_OOR_ERR_EN
//
// Build option
//   DMEM_OOR_ERR_EN : when defined, addresses with any bit set above the RAM
//                     index are granted but answered with err_o=1, rdata_o=0
//                     and no RAM write. When undefined those bits are ignored
//                     and the index wraps modulo the RAM depth.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter  int unsigned ADDR_WIDTH = 10,
  parameter  int unsigned GNT_WAIT   = 0,
  parameter  int unsigned LATENCY    = 1,
  localparam int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [WORD_WIDTH-1:0] rdata_o
`ifdef DMEM_OOR_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
  localparam int unsigned LAST       = LATENCY - 1;
  localparam logic [1:0]  GNT_WAIT_C = 2'(GNT_WAIT);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  oor;
  logic                  unused_addr_bits;

  // The low two bits select a byte inside the word; alignment is the core's
  // responsibility, so they never influence the access.
  assign word_idx = addr_i[ADDR_WIDTH+1:2];

`ifdef DMEM_OOR_ERR_EN
  assign oor              = |addr_i[WORD_WIDTH-1:ADDR_WIDTH+2];
  assign unused_addr_bits = ^addr_i[1:0];
`else
  assign oor              = 1'b0;
  assign unused_addr_bits = ^{addr_i[WORD_WIDTH-1:ADDR_WIDTH+2], addr_i[1:0]};
`endif

  // ---------------------------------------------------------------------------
  // Grant wait-state counter
  // ---------------------------------------------------------------------------
  logic [1:0] wcnt_q, wcnt_d;

  // Grant is purely combinational so GNT_WAIT=0 accepts in the request cycle
  // and sustains one accept per cycle.
  assign gnt_o = req_i && (wcnt_q == GNT_WAIT_C);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise the tool infers a latch to hold the old value.
    wcnt_d = wcnt_q;
    if (!req_i || gnt_o) begin
      wcnt_d = 2'd0;
    end else begin
      wcnt_d = wcnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      wcnt_q <= 2'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte-writable RAM
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic                  ram_we;

  // Out-of-range writes are answered but must never alias onto a real word.
  assign ram_we = gnt_o && we_i && !oor;

  // NOTE: the RAM array has no reset. Contents survive rst_n by design, and a
  // reset on the array would stop it mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipe
  // ---------------------------------------------------------------------------
  // Stage 0 captures the RAM word on the grant edge. Because a write lands on
  // its own grant edge, a read granted one cycle later already sees it.
  logic                  stg0_vld_d;
  logic                  stg0_we_d;
  logic                  stg0_err_d;
  logic [WORD_WIDTH-1:0] stg0_data_d;

  always_comb begin
    stg0_vld_d  = gnt_o;
    stg0_we_d   = we_i;
    stg0_err_d  = oor;
    stg0_data_d = '0;
    if (!we_i && !oor) begin
      stg0_data_d = mem_q[word_idx];
    end
  end

  logic [LATENCY-1:0]    pipe_vld_q;
  logic [LATENCY-1:0]    pipe_we_q;
  logic [LATENCY-1:0]    pipe_err_q;
  logic [WORD_WIDTH-1:0] pipe_data_q [LATENCY];

  // Plain shift register: one slot per in-flight cycle keeps responses in
  // accept order with a fixed latency and no back-pressure path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      pipe_we_q  <= '0;
      pipe_err_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= stg0_vld_d;
      pipe_we_q[0]   <= stg0_we_d;
      pipe_err_q[0]  <= stg0_err_d;
      pipe_data_q[0] <= stg0_data_d;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_we_q[i]   <= pipe_we_q[i-1];
        pipe_err_q[i]  <= pipe_err_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rvalid_o = pipe_vld_q[LAST];

  // Data is only meaningful for a successful read response; gating here keeps
  // rdata_o at zero for idle cycles, write responses and error responses.
  assign rdata_o = (rvalid_o && !pipe_we_q[LAST] && !pipe_err_q[LAST])
                   ? pipe_data_q[LAST] : '0;

`ifdef DMEM_OOR_ERR_EN
  assign err_o = rvalid_o && pipe_err_q[LAST];
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responder instances share one clock:
//   a : GNT_WAIT=0, LATENCY=3  (reset, byte writes, back-to-back, wrap/OOR)
//   b : GNT_WAIT=2, LATENCY=4  (wait states, withdrawal, reset mid-flight)
// Stimulus pushes the hand-computed response (data, err, due cycle) into a
// per-instance queue; a monitor pops and compares on every rvalid_o.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int A_GW  = 0;
  localparam int A_LAT = 3;
  localparam int B_GW  = 2;
  localparam int B_LAT = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk;
  logic        a_rst_n, b_rst_n;
  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr;
  logic        a_we, b_we;
  logic [3:0]  a_be, b_be;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt;
  logic        a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
`ifdef DMEM_OOR_ERR_EN
  logic        a_err, b_err;
`endif

  exp_t a_q[$];
  exp_t b_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  dmem_responder #(.ADDR_WIDTH(10), .GNT_WAIT(A_GW), .LATENCY(A_LAT)) dut_a (
    .clk      (clk),
    .rst_n    (a_rst_n),
    .req_i    (a_req),
    .addr_i   (a_addr),
    .we_i     (a_we),
    .be_i     (a_be),
    .wdata_i  (a_wdata),
    .gnt_o    (a_gnt),
    .rvalid_o (a_rvalid),
    .rdata_o  (a_rdata)
`ifdef DMEM_OOR_ERR_EN
    ,
    .err_o    (a_err)
`endif
  );

  dmem_responder #(.ADDR_WIDTH(10), .GNT_WAIT(B_GW), .LATENCY(B_LAT)) dut_b (
    .clk      (clk),
    .rst_n    (b_rst_n),
    .req_i    (b_req),
    .addr_i   (b_addr),
    .we_i     (b_we),
    .be_i     (b_be),
    .wdata_i  (b_wdata),
    .gnt_o    (b_gnt),
    .rvalid_o (b_rvalid),
    .rdata_o  (b_rdata)
`ifdef DMEM_OOR_ERR_EN
    ,
    .err_o    (b_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (a_rvalid) begin
      check("a_rvalid_expected", 32'(a_q.size() != 0), 32'd1);
      if (a_q.size() != 0) begin
        e = a_q.pop_front();
        check("a_rdata", a_rdata, e.data);
        check("a_latency", cyc, e.due);
`ifdef DMEM_OOR_ERR_EN
        check("a_err", 32'(a_err), 32'(e.err));
`endif
      end
    end else begin
      check("a_rdata_idle", a_rdata, 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rvalid) begin
      check("b_rvalid_expected", 32'(b_q.size() != 0), 32'd1);
      if (b_q.size() != 0) begin
        e = b_q.pop_front();
        check("b_rdata", b_rdata, e.data);
        check("b_latency", cyc, e.due);
`ifdef DMEM_OOR_ERR_EN
        check("b_err", 32'(b_err), 32'(e.err));
`endif
      end
    end else begin
      check("b_rdata_idle", b_rdata, 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request on instance a (sel=0) or b (sel=1). Checks the grant wait,
  // and when track is set queues the expected response.
  task automatic xact(input bit sel, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err,
                      input bit track);
    int   gw  = sel ? B_GW : A_GW;
    int   lat = sel ? B_LAT : A_LAT;
    int   n   = 0;
    bit   got = 0;
    exp_t e;
    if (sel) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_be = be; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_be = be; a_wdata = wdata;
    end
    while (!got && n < 8) begin
      @(negedge clk);
      if (sel ? b_gnt : a_gnt) begin
        got = 1;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check(sel ? "b_gnt_wait" : "a_gnt_wait", n, gw);
    if (got && track) begin
      e.data = exp_data;
      e.err  = exp_err;
      e.due  = cyc + lat;
      if (sel) b_q.push_back(e);
      else     a_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel) b_req = 1'b0;
    else     a_req = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int n = 0;
    while (n < 20 && (sel ? b_q.size() : a_q.size()) != 0) begin
      @(negedge clk);
      n++;
    end
    check(sel ? "b_drain" : "a_drain", sel ? b_q.size() : a_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_req = 1'b1;   b_req = 1'b1;
    a_we = 1'b0;    b_we = 1'b0;
    a_addr = '0;    b_addr = '0;
    a_be = 4'hF;    b_be = 4'hF;
    a_wdata = '0;   b_wdata = '0;

    // Reset held with requests pending: no responses, grant only for GNT_WAIT=0.
    idle(1);
    @(negedge clk);
    check("rst_a_gnt", 32'(a_gnt), 32'd1);
    check("rst_b_gnt", 32'(b_gnt), 32'd0);
    check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    idle(1);
    @(negedge clk);
    check("rst_a_rvalid_2", 32'(a_rvalid), 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    idle(1);
    a_req = 1'b0; b_req = 1'b0;
    idle(1);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    idle(2);

    // Byte-lane writes and read-after-write.
    xact(0, 1, 32'h40, 4'hF, 32'h11223344, 32'h0, 0, 1);
    xact(0, 1, 32'h40, 4'h2, 32'hAABBCCDD, 32'h0, 0, 1);
    xact(0, 0, 32'h40, 4'hF, 32'h0, 32'h1122CC44, 0, 1);
    xact(0, 1, 32'h40, 4'h0, 32'hFFFFFFFF, 32'h0, 0, 1);
    xact(0, 1, 32'h40, 4'h9, 32'h55667788, 32'h0, 0, 1);
    xact(0, 0, 32'h40, 4'hF, 32'h0, 32'h5522CC88, 0, 1);

    // Back-to-back write then read of the same word.
    xact(0, 1, 32'h8, 4'hF, 32'hDEADBEEF, 32'h0, 0, 1);
    xact(0, 0, 32'h8, 4'hF, 32'h0, 32'hDEADBEEF, 0, 1);

    // Eight consecutive writes, then eight consecutive reads.
    for (int k = 0; k < 8; k++)
      xact(0, 1, 32'h200 + 32'(4*k), 4'hF, 32'hA5A50000 + 32'(k), 32'h0, 0, 1);
    for (int k = 0; k < 8; k++)
      xact(0, 0, 32'h200 + 32'(4*k), 4'hF, 32'h0, 32'hA5A50000 + 32'(k), 0, 1);

    // Byte offset within the word is ignored.
    xact(0, 0, 32'h203, 4'hF, 32'h0, 32'hA5A50000, 0, 1);

    // Address above the RAM index.
`ifdef DMEM_OOR_ERR_EN
    xact(0, 1, 32'h0, 4'hF, 32'h12345678, 32'h0, 0, 1);
    xact(0, 1, 32'h1000, 4'hF, 32'h00000055, 32'h0, 1, 1);
    xact(0, 0, 32'h0, 4'hF, 32'h0, 32'h12345678, 0, 1);
    xact(0, 0, 32'h1004, 4'hF, 32'h0, 32'h0, 1, 1);
`else
    xact(0, 1, 32'h1000, 4'hF, 32'h00000055, 32'h0, 0, 1);
    xact(0, 0, 32'h0, 4'hF, 32'h0, 32'h00000055, 0, 1);
`endif
    drain(0);

    // Wait states: held request grants in the third cycle.
    xact(1, 1, 32'h300, 4'hF, 32'h01020304, 32'h0, 0, 1);

    // Withdrawn write: no grant, no RAM change, counter cleared.
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h300; b_be = 4'hF; b_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("b_withdraw_gnt0", 32'(b_gnt), 32'd0);
    @(posedge clk);
    #1;
    b_req = 1'b0;
    @(negedge clk);
    check("b_withdraw_gnt1", 32'(b_gnt), 32'd0);
    idle(1);
    xact(1, 0, 32'h300, 4'hF, 32'h0, 32'h01020304, 0, 1);

    // Reset mid-flight: two reads in the pipe are flushed, RAM survives.
    xact(1, 1, 32'h100, 4'hF, 32'hCAFEF00D, 32'h0, 0, 1);
    drain(1);
    xact(1, 0, 32'h100, 4'hF, 32'h0, 32'h0, 0, 0);
    xact(1, 0, 32'h300, 4'hF, 32'h0, 32'h0, 0, 0);
    b_rst_n = 1'b0;
    @(negedge clk);
    check("b_midrst_rvalid", 32'(b_rvalid), 32'd0);
    idle(3);
    b_rst_n = 1'b1;
    idle(8);
    xact(1, 0, 32'h100, 4'hF, 32'h0, 32'hCAFEF00D, 0, 1);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder sitting on the memory side of the MMC: it receives the MMC's offset-translated data request (`data_*_o` from the MMC) and answers it with grant, read data and response-valid. It holds a word-organised, byte-writable RAM, inserts a programmable number of grant wait states, and returns responses in order after a fixed pipeline latency. It serves both as the on-chip data memory and as the protocol model the core-side request/grant logic is verified against.

## Interface
- `ADDR_WIDTH`, 10: word-index bits; `DEPTH = 2**ADDR_WIDTH` 32-bit words.
- `GNT_WAIT`, 0: cycles `req_i` must be held before `gnt_o` rises (0..3).
- `LATENCY`, 1: cycles from grant edge to `rvalid_o` (1..4).
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_i`  in  1  request valid.
- `addr_i`  in  WORD_WIDTH  byte address, relative to DMEM base.
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  4  byte enables; bit n covers `wdata_i[8n+7:8n]`.
- `wdata_i`  in  WORD_WIDTH  write data.
- `gnt_o`  out  1  request accepted this cycle.
- `rvalid_o`  out  1  one-cycle response strobe.
- `rdata_o`  out  WORD_WIDTH  read data; valid only with `rvalid_o`.
- `err_o`  out  1  response error; valid only with `rvalid_o` (present only under `DMEM_OOR_ERR_EN`).

## Operation
- Word index = `addr_i[ADDR_WIDTH+1:2]`; `addr_i[1:0]` ignored (alignment is the core's job).
- Wait counter `wcnt` (2 bits): increments each cycle `req_i && !gnt_o`; `gnt_o = req_i && (wcnt == GNT_WAIT)` (combinational from `wcnt`, `req_i`); `wcnt` clears on grant or when `req_i` drops. `GNT_WAIT=0` → same-cycle grant, back-to-back accepts every cycle.
- Initiator holds `req_i`, `addr_i`, `we_i`, `be_i`, `wdata_i` stable until `gnt_o`; responder samples them only on the grant edge.
- Accepted write: enabled bytes written to RAM on the grant edge; disabled bytes unchanged; `be_i=0` writes nothing but still responds.
- Accepted read: RAM read on the grant edge; result carried through the response pipe.
- Response pipe: `LATENCY`-deep shift of {valid, we, data, err}; stage 0 loaded on grant edge; last stage drives outputs. Responses strictly in accept order, one per accepted request, never dropped.
- Write responses: `rvalid_o=1`, `rdata_o=0`.
- Read-after-write: a read granted the cycle after a write to the same word returns the new data. No same-cycle hazard (one grant per cycle).
- `rdata_o` forced 0 whenever `rvalid_o=0`.

## Timing
- Reset values: `gnt_o`=0 (combinational, follows `req_i` with `wcnt`=0 after reset), `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `wcnt`=0, pipe valid bits=0.
- Request-to-grant: `GNT_WAIT` cycles. Grant-to-`rvalid_o`: `LATENCY` cycles (grant in cycle t → `rvalid_o` high in cycle t+LATENCY).
- Throughput: one transaction per `GNT_WAIT+1` cycles; up to `LATENCY` responses in flight.
- Reset mid-operation: pipe flushed, no `rvalid_o` after `rst_n` releases for pre-reset grants; RAM contents not cleared; writes granted before reset remain.
- `req_i` withdrawn before grant: legal, no side effect, `wcnt` cleared.

## Configuration
- `DMEM_OOR_ERR_EN` defined: request with `addr_i[WORD_WIDTH-1:ADDR_WIDTH+2] != 0` is still granted and responds at normal latency with `err_o=1`, `rdata_o=0`, no RAM write. `err_o` port exists.
- Not defined: upper address bits ignored, index wraps modulo `DEPTH`; `err_o` port absent.

## Test plan
- Reset: hold `rst_n=0` with `req_i=1` → `rvalid_o=0`, `rdata_o=0`; `gnt_o` high once `GNT_WAIT=0`, no response until released.
- Byte write: write 0x11223344 be=0xF to 0x40, then be=0x2 wdata 0xAABBCCDD, read 0x40 → rdata 0x1122CC44 exactly `LATENCY` cycles after read grant.
- Back-to-back (`GNT_WAIT=0`, `LATENCY=3`): write 0xDEADBEEF to 0x8 then read 0x8 next cycle → 0xDEADBEEF; 8 consecutive reads → 8 in-order `rvalid_o` pulses, no gaps.
- Wait states (`GNT_WAIT=2`): hold `req_i` → `gnt_o` in 3rd cycle; drop `req_i` after 1 cycle → no grant, reissue needs full 2 waits.
- Reset mid-flight (`LATENCY=4`): grant 2 reads, assert `rst_n=0` 1 cycle later → no `rvalid_o` after release; prior write still readable.
- Out-of-range, `ADDR_WIDTH=10`, addr 0x1000: with `DMEM_OOR_ERR_EN` write 0x55 → `err_o=1`, word 0 unchanged; without → word 0 reads 0x55.
